// File: rtl/vram_write_ctrl.sv
// vram_write_ctrl: turns MCU bus strobes into auto-incrementing byte writes to VRAM.
// A small FIFO of {address, data} absorbs bursts while the arbiter withholds grant.
// Build option: define VRAM_WRITE_CTRL_DROP_COUNT_EN to build the saturating drop counter;
// when undefined drop_count is tied to zero.
module vram_write_ctrl #(
  parameter int unsigned ADDR_W          = 19,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned WRITE_CYCLES    = 2,
  parameter logic [7:0]  SET_ADDRESS_CMD = 8'h02
) (
  input  logic                          sysclk,
  input  logic                          rst,
  input  logic                          cmdclk,
  input  logic                          dataclk,
  input  logic [7:0]                    data_in,
  input  logic [31:0]                   address_in,
  output logic                          mem_req,
  input  logic                          mem_gnt,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [7:0]                    mem_data,
  output logic                          mem_we,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          busy,
  output logic [15:0]                   drop_count
);

  localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = IdxW + 1;
  localparam int unsigned CntW = $clog2(WRITE_CYCLES + 1);
  localparam logic [LvlW-1:0] Depth   = LvlW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] LastCyc = CntW'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWrite} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [7:0]        fifo_data_q [FIFO_DEPTH];
  logic [IdxW-1:0]   rd_idx_q, wr_idx_q, rd_next;
  logic [LvlW-1:0]   level_q, level_d;
  logic [CntW-1:0]   cyc_q, cyc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              overflow_q;
  logic              set_addr, pop, push, drop;

  assign set_addr = cmdclk && (data_in == SET_ADDRESS_CMD);
  // The head leaves the FIFO on the last mem_we cycle; a push that same cycle fits even if full.
  assign pop      = (state_q == StWrite) && (cyc_q == LastCyc);
  assign push     = dataclk && ((level_q < Depth) || pop);
  assign drop     = dataclk && !push;
  assign rd_next  = rd_idx_q + IdxW'(1);
  assign level_d  = level_q + LvlW'(push) - LvlW'(pop);

  // Write pointer: data advances it, a same-cycle SET_ADDRESS overrides the advance.
  always_comb begin
    ptr_d = ptr_q;
    if (push) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
    if (set_addr) begin
      ptr_d = address_in[ADDR_W-1:0];
    end
  end

  // Memory-port FSM next state and head capture.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (level_q != '0) begin
          state_d = StReq;
          addr_d  = fifo_addr_q[rd_idx_q];
          data_d  = fifo_data_q[rd_idx_q];
        end
      end
      StReq: begin
        if (mem_gnt) begin
          state_d = StWrite;
          cyc_d   = '0;
        end
      end
      StWrite: begin
        if (pop) begin
          if (level_q > LvlW'(1)) begin
            state_d = StReq;
            addr_d  = fifo_addr_q[rd_next];
            data_d  = fifo_data_q[rd_next];
          end else if (push) begin
            // Only entry left is the one arriving now; forward it as the new head.
            state_d = StReq;
            addr_d  = ptr_q;
            data_d  = data_in;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      level_q    <= '0;
      cyc_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      level_q <= level_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      if (push) begin
        wr_idx_q <= wr_idx_q + IdxW'(1);
      end
      if (pop) begin
        rd_idx_q <= rd_next;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are meaningless once the indices are reset.
  always_ff @(posedge sysclk) begin
    if (push) begin
      fifo_addr_q[wr_idx_q] <= ptr_q;
      fifo_data_q[wr_idx_q] <= data_in;
    end
  end

`ifdef VRAM_WRITE_CTRL_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of dropped bytes.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'h0000;
`endif

  // Address bits above the VRAM range are intentionally ignored.
  if (ADDR_W < 32) begin : g_unused_addr
    logic unused_addr_hi;
    assign unused_addr_hi = ^address_in[31:ADDR_W];
  end

  assign mem_req    = (state_q != StIdle);
  assign mem_we     = (state_q == StWrite);
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != StIdle) || (level_q != '0);

endmodule

// File: tb/tb_vram_write_ctrl.sv
// Scoreboard bench for vram_write_ctrl: a byte-stream model predicts writes, occupancy,
// overflow and drops; a negedge monitor checks every completed VRAM write against it.
module tb_vram_write_ctrl;

  localparam int unsigned ADDR_W       = 19;
  localparam int unsigned FIFO_DEPTH   = 8;
  localparam int unsigned WRITE_CYCLES = 2;
  localparam logic [7:0]  SET_CMD      = 8'h02;
  localparam longint unsigned ADDR_SPAN = 64'd1 << ADDR_W;
`ifdef VRAM_WRITE_CTRL_DROP_COUNT_EN
  localparam int T3_DROPS = 2;
`else
  localparam int T3_DROPS = 0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic              sysclk = 1'b0;
  logic              rst = 1'b1;
  logic              cmdclk = 1'b0;
  logic              dataclk = 1'b0;
  logic [7:0]        data_in = 8'h00;
  logic [31:0]       address_in = 32'h0;
  logic              mem_gnt = 1'b0;
  logic              mem_req, mem_we, overflow, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [3:0]        fifo_level;
  logic [15:0]       drop_count;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  wr_t             exp_q[$];
  longint unsigned m_ptr = 0;
  int              m_occ = 0;
  bit              m_ovf = 1'b0;
  int              m_drops = 0;
  bit              pop_pending = 1'b0;
  bit              acc;
  wr_t             new_w;

  // Monitor state
  bit                prev_we = 1'b0;
  int                we_len = 0;
  int                writes_done = 0;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        cur_data;
  wr_t               exp_w;

  vram_write_ctrl #(
    .ADDR_W         (ADDR_W),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .WRITE_CYCLES   (WRITE_CYCLES),
    .SET_ADDRESS_CMD(SET_CMD)
  ) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .cmdclk    (cmdclk),
    .dataclk   (dataclk),
    .data_in   (data_in),
    .address_in(address_in),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .busy      (busy),
    .drop_count(drop_count)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_drops();
`ifdef VRAM_WRITE_CTRL_DROP_COUNT_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  // Model: FIFO occupancy as a count, pops taken from observed write completions.
  initial forever begin
    @(posedge sysclk or posedge rst);
    if (rst) begin
      exp_q.delete();
      m_ptr       = 0;
      m_occ       = 0;
      m_ovf       = 1'b0;
      m_drops     = 0;
      pop_pending = 1'b0;
    end else begin
      acc = dataclk && ((m_occ < int'(FIFO_DEPTH)) || pop_pending);
      if (dataclk && !acc) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
      if (acc) begin
        new_w.addr = ADDR_W'(m_ptr);
        new_w.data = data_in;
        exp_q.push_back(new_w);
        m_ptr = (m_ptr + 1) % ADDR_SPAN;
      end
      if (cmdclk && (data_in == SET_CMD)) m_ptr = 64'(address_in) % ADDR_SPAN;
      m_occ = m_occ + (acc ? 1 : 0) - (pop_pending ? 1 : 0);
      pop_pending = 1'b0;
    end
  end

  // Monitor: checks status every cycle and each write pulse against the scoreboard.
  initial forever begin
    @(negedge sysclk);
    if (rst) begin
      prev_we = 1'b0;
      we_len  = 0;
    end else begin
      check("level", fifo_level, m_occ);
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, exp_drops());
      if (mem_we) begin
        check("req_during_we", mem_req, 1);
        if (!prev_we) begin
          cur_addr = mem_addr;
          cur_data = mem_data;
          we_len   = 1;
        end else begin
          we_len++;
          check("addr_stable", mem_addr, cur_addr);
          check("data_stable", mem_data, cur_data);
        end
        if (we_len == int'(WRITE_CYCLES)) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     cur_addr, cur_data);
          end else begin
            exp_w = exp_q.pop_front();
            check("wr_addr", cur_addr, exp_w.addr);
            check("wr_data", cur_data, exp_w.data);
          end
          writes_done++;
          pop_pending = 1'b1;
        end else if (we_len > int'(WRITE_CYCLES)) begin
          check("we_length", we_len, WRITE_CYCLES);
        end
      end else if (prev_we && (we_len < int'(WRITE_CYCLES))) begin
        check("we_length", we_len, WRITE_CYCLES);
      end
      prev_we = mem_we;
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_addr(input logic [31:0] a);
    cmdclk     = 1'b1;
    data_in    = SET_CMD;
    address_in = a;
    tick();
    cmdclk = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    dataclk = 1'b1;
    data_in = d;
    tick();
    dataclk = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || (exp_q.size() != 0)) && (n < 300)) begin
      tick();
      n++;
    end
    check({name, "_idle"}, busy, 0);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int w0;
    int n;
    repeat (3) @(posedge sysclk);
    #1;
    rst = 1'b0;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drops", drop_count, 0);
    tick();

    // Basic burst with grant tied high, plus request latency
    mem_gnt = 1'b1;
    w0 = writes_done;
    set_addr(32'h0000_1000);
    send(8'h11);
    @(negedge sysclk);
    check("req_latency_1", mem_req, 0);
    @(negedge sysclk);
    check("req_latency_2", mem_req, 1);
    tick();
    send(8'h22);
    send(8'h33);
    wait_idle("t1");
    check("t1_writes", writes_done - w0, 3);

    // Pointer wrap at the top of the VRAM range
    set_addr(32'hFFFF_FFFF);
    send(8'hAA);
    send(8'hBB);
    wait_idle("t2");

    // Overflow with grant held low
    mem_gnt = 1'b0;
    set_addr(32'h0);
    for (int i = 0; i < 10; i++) send(8'h30 + 8'(i));
    check("t3_level", fifo_level, 8);
    check("t3_overflow", overflow, 1);
    check("t3_drops", drop_count, T3_DROPS);
    w0 = writes_done;
    mem_gnt = 1'b1;
    wait_idle("t3");
    check("t3_writes", writes_done - w0, 8);
    send(8'hEE);
    wait_idle("t3b");

    // Push on a full FIFO coinciding with a pop is accepted
    reset_pulse();
    mem_gnt = 1'b0;
    set_addr(32'h300);
    for (int i = 0; i < 8; i++) send(8'h60 + 8'(i));
    check("t4_full", fifo_level, 8);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    n = 0;
    while (!mem_we && (n < 10)) begin
      tick();
      n++;
    end
    check("t4_we_start", mem_we, 1);
    repeat (WRITE_CYCLES - 1) tick();
    send(8'h77);
    check("t4_level", fifo_level, 8);
    check("t4_overflow", overflow, 0);
    mem_gnt = 1'b1;
    wait_idle("t4");

    // Command and data in the same cycle
    set_addr(32'h40);
    cmdclk     = 1'b1;
    dataclk    = 1'b1;
    data_in    = SET_CMD;
    address_in = 32'h200;
    tick();
    cmdclk  = 1'b0;
    dataclk = 1'b0;
    send(8'h5A);
    cmdclk     = 1'b1;
    dataclk    = 1'b1;
    data_in    = 8'h5B;
    address_in = 32'h999;
    tick();
    cmdclk  = 1'b0;
    dataclk = 1'b0;
    send(8'h5C);
    wait_idle("t5");

    // Reset in the middle of a write
    mem_gnt = 1'b0;
    set_addr(32'h50);
    send(8'hC1);
    send(8'hC2);
    send(8'hC3);
    mem_gnt = 1'b1;
    n = 0;
    while (!mem_we && (n < 10)) begin
      tick();
      n++;
    end
    check("t6_we_start", mem_we, 1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_we", mem_we, 0);
    check("t6_req", mem_req, 0);
    check("t6_level", fifo_level, 0);
    check("t6_busy", busy, 0);
    tick();
    rst = 1'b0;
    w0 = writes_done;
    repeat (20) tick();
    check("t6_no_writes", writes_done - w0, 0);
    send(8'h99);
    wait_idle("t6");

    // Randomized traffic with random grant
    for (int i = 0; i < 400; i++) begin
      mem_gnt    = ($urandom_range(0, 3) != 0);
      dataclk    = ($urandom_range(0, 1) == 1);
      cmdclk     = ($urandom_range(0, 7) == 0);
      data_in    = (cmdclk && ($urandom_range(0, 1) == 1)) ? SET_CMD : 8'($urandom);
      address_in = $urandom;
      tick();
    end
    dataclk = 1'b0;
    cmdclk  = 1'b0;
    mem_gnt = 1'b1;
    wait_idle("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
